// File: rtl/control_unit_pkg.sv
// Shared encodings for the RV64 multi-cycle control unit: opcodes, legal funct3 values,
// FSM states, instruction classes and the registered control-strobe bundle.
package control_unit_pkg;

   localparam logic [6:0] OP_ALU_R  = 7'b0110011;
   localparam logic [6:0] OP_ALU_I  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD    = 3'b000;
   localparam logic [2:0] F3_DWORD  = 3'b011;
   localparam logic [2:0] F3_BEQ    = 3'b000;
   localparam logic [2:0] F3_BNE    = 3'b001;
   localparam logic [2:0] F3_BLT    = 3'b100;
   localparam logic [2:0] F3_BGE    = 3'b101;
   localparam logic [2:0] F3_BLTU   = 3'b110;
   localparam logic [2:0] F3_BGEU   = 3'b111;

   typedef enum logic [2:0] {
      ST_RESET,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_HALT
   } state_e;

   typedef enum logic [2:0] {
      CLS_ALU_R,
      CLS_ALU_I,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_ILLEGAL
   } instr_class_e;

   typedef struct packed {
      logic sub;
      logic din2_imm;
      logic rf_din_alu;
      logic we_rf;
      logic we_mem;
      logic load_pc;
      logic pc_next_sel;
      logic reset_pc;
      logic halted;
   } ctrl_t;

   // Moore decode of the strobes for a given state and latched instruction class.
   function automatic ctrl_t decode_ctrl(input state_e st, input instr_class_e cls,
                                         input logic alu_sub);
      ctrl_t c;
      logic  imm_class;
      c         = '0;
      imm_class = (cls == CLS_ALU_I) || (cls == CLS_LOAD) || (cls == CLS_STORE);
      case (st)
         ST_RESET: c.reset_pc = 1'b1;
         ST_EXEC: begin
            c.din2_imm = imm_class;
            c.sub      = ((cls == CLS_ALU_R) && alu_sub) || (cls == CLS_BRANCH);
            if (cls == CLS_BRANCH) begin
               c.load_pc     = 1'b1;
               c.pc_next_sel = 1'b1;
            end
         end
         ST_MEM: begin
            c.din2_imm = imm_class;
            if (cls == CLS_STORE) begin
               c.we_mem  = 1'b1;
               c.load_pc = 1'b1;
            end
         end
         ST_WB: begin
            c.din2_imm   = imm_class;
            c.sub        = (cls == CLS_ALU_R) && alu_sub;
            c.we_rf      = 1'b1;
            c.load_pc    = 1'b1;
            c.rf_din_alu = (cls != CLS_LOAD);
         end
         ST_HALT: c.halted = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/instr_class_decoder.sv
// Combinational classifier: maps opcode/funct3/funct7[5] onto an instruction class
// and flags any combination the datapath cannot execute.
module instr_class_decoder
   import control_unit_pkg::*;
(
   input  logic [6:0]   opcode,
   input  logic [2:0]   funct3,
   input  logic         funct7_5,
   output instr_class_e cls,
   output logic         illegal,
   output logic         alu_sub
);

   // NOTE: cls gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      cls = CLS_ILLEGAL;
      case (opcode)
         OP_ALU_R:  if (funct3 == F3_ADD)   cls = CLS_ALU_R;
         OP_ALU_I:  if (funct3 == F3_ADD)   cls = CLS_ALU_I;
         OP_LOAD:   if (funct3 == F3_DWORD) cls = CLS_LOAD;
         OP_STORE:  if (funct3 == F3_DWORD) cls = CLS_STORE;
         OP_BRANCH: if (funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU})
                       cls = CLS_BRANCH;
         default:   cls = CLS_ILLEGAL;
      endcase
   end

   assign illegal = (cls == CLS_ILLEGAL);
   assign alu_sub = funct7_5 && (cls == CLS_ALU_R);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM for the RV64 datapath: FETCH/DECODE/EXEC/MEM/WB sequencing
// with registered Moore strobes; load_ir alone follows run combinationally in FETCH.
module control_unit
   import control_unit_pkg::*;
(
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       run,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic       load_ir,
   output logic       sub,
   output logic       ULA_din2_sel,
   output logic       RF_din_sel,
   output logic       WE_RF,
   output logic       WE_MEM,
   output logic       load_pc,
   output logic       pc_next_sel,
   output logic       reset_pc,
   output logic       halted
);

   state_e       state_q, state_d;
   instr_class_e cls_q, cls_d;
   logic         alu_sub_q, alu_sub_d;
   ctrl_t        ctrl_q, ctrl_d;

   instr_class_e dec_cls;
   logic         dec_illegal;
   logic         dec_alu_sub;

   instr_class_decoder u_decoder (
      .opcode   (opcode),
      .funct3   (funct3),
      .funct7_5 (funct7_5),
      .cls      (dec_cls),
      .illegal  (dec_illegal),
      .alu_sub  (dec_alu_sub)
   );

   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      alu_sub_d = alu_sub_q;
      case (state_q)
         ST_RESET:  state_d = ST_FETCH;
         ST_FETCH:  if (run) state_d = ST_DECODE;
         ST_DECODE: begin
            cls_d     = dec_cls;
            alu_sub_d = dec_alu_sub;
            state_d   = dec_illegal ? ST_HALT : ST_EXEC;
         end
         ST_EXEC: begin
            if (cls_q == CLS_BRANCH)
               state_d = ST_FETCH;
            else if ((cls_q == CLS_LOAD) || (cls_q == CLS_STORE))
               state_d = ST_MEM;
            else
               state_d = ST_WB;
         end
         ST_MEM:    state_d = (cls_q == CLS_LOAD) ? ST_WB : ST_FETCH;
         ST_WB:     state_d = ST_FETCH;
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_RESET;
      endcase
      // Strobes are decoded from the next state so the flops hold the value for state_q.
      ctrl_d = decode_ctrl(state_d, cls_d, alu_sub_d);
   end

   // NOTE: sequential state uses non-blocking assignments only; the async reset clears
   // every strobe in the same instant RST_N falls, including a live WE_MEM/WE_RF.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_RESET;
         cls_q     <= CLS_ALU_R;
         alu_sub_q <= 1'b0;
         ctrl_q    <= decode_ctrl(ST_RESET, CLS_ALU_R, 1'b0);
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         alu_sub_q <= alu_sub_d;
         ctrl_q    <= ctrl_d;
      end
   end

   assign load_ir      = (state_q == ST_FETCH) && run;
   assign sub          = ctrl_q.sub;
   assign ULA_din2_sel = ctrl_q.din2_imm;
   assign RF_din_sel   = ctrl_q.rf_din_alu;
   assign WE_RF        = ctrl_q.we_rf;
   assign WE_MEM       = ctrl_q.we_mem;
   assign load_pc      = ctrl_q.load_pc;
   assign pc_next_sel  = ctrl_q.pc_next_sel;
   assign reset_pc     = ctrl_q.reset_pc;
   assign halted       = ctrl_q.halted;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed instruction table, corner sequences
// (reset, stall, illegal, reset mid-store) and random instruction streams vs a cycle model.
module tb_control_unit;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       run;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_5;
   logic       load_ir, sub, ULA_din2_sel, RF_din_sel, WE_RF, WE_MEM;
   logic       load_pc, pc_next_sel, reset_pc, halted;

   control_unit dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .run          (run),
      .opcode       (opcode),
      .funct3       (funct3),
      .funct7_5     (funct7_5),
      .load_ir      (load_ir),
      .sub          (sub),
      .ULA_din2_sel (ULA_din2_sel),
      .RF_din_sel   (RF_din_sel),
      .WE_RF        (WE_RF),
      .WE_MEM       (WE_MEM),
      .load_pc      (load_pc),
      .pc_next_sel  (pc_next_sel),
      .reset_pc     (reset_pc),
      .halted       (halted)
   );

   always #5 CLK = ~CLK;

   localparam logic [9:0] V_LOAD_IR  = 10'b10_0000_0000;
   localparam logic [9:0] V_SUB      = 10'b01_0000_0000;
   localparam logic [9:0] V_DIN2     = 10'b00_1000_0000;
   localparam logic [9:0] V_RFDIN    = 10'b00_0100_0000;
   localparam logic [9:0] V_WE_RF    = 10'b00_0010_0000;
   localparam logic [9:0] V_WE_MEM   = 10'b00_0001_0000;
   localparam logic [9:0] V_LOAD_PC  = 10'b00_0000_1000;
   localparam logic [9:0] V_PC_NEXT  = 10'b00_0000_0100;
   localparam logic [9:0] V_RESET_PC = 10'b00_0000_0010;
   localparam logic [9:0] V_HALTED   = 10'b00_0000_0001;

   localparam int M_ALU_R = 0, M_ALU_I = 1, M_LOAD = 2, M_STORE = 3, M_BRANCH = 4, M_ILL = 5;

   int checks = 0;
   int errors = 0;

   logic [9:0] act_vec;
   assign act_vec = {load_ir, sub, ULA_din2_sel, RF_din_sel, WE_RF, WE_MEM,
                     load_pc, pc_next_sel, reset_pc, halted};

   task automatic check(input string name, input logic [9:0] exp);
      checks++;
      if (act_vec !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (ir,sub,din2,rfdin,we_rf,we_mem,ld_pc,pc_sel,rst_pc,halt)",
                  name, act_vec, exp);
      end
   endtask

   // Instruction classification straight from the legal-instruction list.
   function automatic int m_class(input logic [6:0] op, input logic [2:0] f3);
      if (op == 7'b0110011 && f3 == 3'd0) return M_ALU_R;
      if (op == 7'b0010011 && f3 == 3'd0) return M_ALU_I;
      if (op == 7'b0000011 && f3 == 3'd3) return M_LOAD;
      if (op == 7'b0100011 && f3 == 3'd3) return M_STORE;
      if (op == 7'b1100011 && f3 != 3'd2 && f3 != 3'd3) return M_BRANCH;
      return M_ILL;
   endfunction

   function automatic int m_cpi(input int cls);
      case (cls)
         M_BRANCH: return 3;
         M_LOAD:   return 5;
         default:  return 4;
      endcase
   endfunction

   // Expected strobes in cycle k (1 = FETCH entry) of an instruction.
   function automatic logic [9:0] m_out(input logic [6:0] op, input logic [2:0] f3,
                                        input logic f75, input int k);
      int         cls;
      logic [9:0] v;
      cls = m_class(op, f3);
      if (k == 1) return V_LOAD_IR;
      if (k == 2) return '0;
      if (cls == M_ILL) return V_HALTED;
      v = '0;
      if (cls == M_ALU_I || cls == M_LOAD || cls == M_STORE) v |= V_DIN2;
      if ((cls == M_ALU_R && f75) || cls == M_BRANCH) v |= V_SUB;
      if (k == m_cpi(cls)) begin
         v |= V_LOAD_PC;
         if (cls == M_BRANCH) v |= V_PC_NEXT;
         if (cls == M_ALU_R || cls == M_ALU_I || cls == M_LOAD) v |= V_WE_RF;
         if (cls == M_ALU_R || cls == M_ALU_I) v |= V_RFDIN;
         if (cls == M_STORE) v |= V_WE_MEM;
      end
      return v;
   endfunction

   // All tasks start and end at the drive point: 1 time unit after a rising edge.
   task automatic do_reset();
      RST_N = 1'b0;
      run   = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         check("reset_hold", V_RESET_PC);
      end
      @(posedge CLK); #1;
      RST_N = 1'b1;
      @(negedge CLK);
      check("reset_first_cycle", V_RESET_PC);
      @(posedge CLK); #1;
      @(negedge CLK);
      check("reset_to_fetch", '0);
      @(posedge CLK); #1;
   endtask

   task automatic stall(input int n);
      run    = 1'b0;
      opcode = 7'($urandom);
      funct3 = 3'($urandom);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         check("fetch_stall", '0);
         @(posedge CLK); #1;
      end
   endtask

   // Fields are scrambled after DECODE to show the sequence no longer depends on them.
   task automatic exec_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f75, input int cycles);
      opcode   = op;
      funct3   = f3;
      funct7_5 = f75;
      run      = 1'b1;
      for (int k = 1; k <= cycles; k++) begin
         @(negedge CLK);
         check($sformatf("%s_c%0d", name, k), m_out(op, f3, f75, k));
         @(posedge CLK); #1;
         if (k == 2) begin
            opcode   = 7'($urandom);
            funct3   = 3'($urandom);
            funct7_5 = 1'($urandom);
            run      = 1'($urandom);
         end
      end
   endtask

   typedef struct {
      string      name;
      logic [6:0] op;
      logic [2:0] f3;
      logic       f75;
      int         cpi;
   } vec_t;

   vec_t tbl [14];
   logic [2:0] br_f3 [6];

   initial begin
      tbl[0]  = '{"add",      7'b0110011, 3'b000, 1'b0, 4};
      tbl[1]  = '{"sub",      7'b0110011, 3'b000, 1'b1, 4};
      tbl[2]  = '{"addi",     7'b0010011, 3'b000, 1'b1, 4};
      tbl[3]  = '{"ld",       7'b0000011, 3'b011, 1'b0, 5};
      tbl[4]  = '{"sd",       7'b0100011, 3'b011, 1'b0, 4};
      tbl[5]  = '{"beq",      7'b1100011, 3'b000, 1'b0, 3};
      tbl[6]  = '{"loop_addi",7'b0010011, 3'b000, 1'b0, 4};
      tbl[7]  = '{"loop_bne", 7'b1100011, 3'b001, 1'b0, 3};
      tbl[8]  = '{"loop_addi",7'b0010011, 3'b000, 1'b0, 4};
      tbl[9]  = '{"loop_bne", 7'b1100011, 3'b001, 1'b1, 3};
      tbl[10] = '{"blt",      7'b1100011, 3'b100, 1'b0, 3};
      tbl[11] = '{"bge",      7'b1100011, 3'b101, 1'b0, 3};
      tbl[12] = '{"bltu",     7'b1100011, 3'b110, 1'b0, 3};
      tbl[13] = '{"bgeu",     7'b1100011, 3'b111, 1'b0, 3};
      br_f3   = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

      opcode   = '0;
      funct3   = '0;
      funct7_5 = 1'b0;
      do_reset();
      stall(5);

      for (int i = 0; i < 14; i++)
         exec_instr(tbl[i].name, tbl[i].op, tbl[i].f3, tbl[i].f75, tbl[i].cpi);

      for (int n = 0; n < 150; n++) begin
         int         cls;
         logic [6:0] op;
         logic [2:0] f3;
         cls = $urandom_range(0, 4);
         case (cls)
            M_ALU_R: begin op = 7'b0110011; f3 = 3'b000; end
            M_ALU_I: begin op = 7'b0010011; f3 = 3'b000; end
            M_LOAD:  begin op = 7'b0000011; f3 = 3'b011; end
            M_STORE: begin op = 7'b0100011; f3 = 3'b011; end
            default: begin op = 7'b1100011; f3 = br_f3[$urandom_range(0, 5)]; end
         endcase
         if ($urandom_range(0, 3) == 0) stall($urandom_range(1, 3));
         exec_instr("rand", op, f3, 1'($urandom), m_cpi(m_class(op, f3)));
      end

      exec_instr("ld_funct3_010", 7'b0000011, 3'b010, 1'b0, 10);
      do_reset();
      exec_instr("branch_funct3_010", 7'b1100011, 3'b010, 1'b0, 6);
      do_reset();
      exec_instr("alu_funct3_001", 7'b0110011, 3'b001, 1'b1, 6);
      do_reset();
      exec_instr("add_after_halt", 7'b0110011, 3'b000, 1'b0, 4);

      opcode = 7'b0100011;
      funct3 = 3'b011;
      run    = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge CLK);
         check($sformatf("sd_rst_c%0d", k), m_out(7'b0100011, 3'b011, 1'b0, k));
         @(posedge CLK); #1;
      end
      @(negedge CLK);
      check("sd_mem_cycle", V_DIN2 | V_WE_MEM | V_LOAD_PC);
      #1 RST_N = 1'b0;
      #1 check("sd_async_reset", V_RESET_PC);
      @(posedge CLK); #1;
      do_reset();
      exec_instr("ld_after_reset", 7'b0000011, 3'b011, 1'b0, 5);
      exec_instr("sub_after_reset", 7'b0110011, 3'b000, 1'b1, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
